// File: rtl/stream_demux.sv
// 1-to-NUM_CH valid/ready stream demultiplexer with one registered slot per channel.
// Supports unicast by select, broadcast to enabled channels, and a saturating drop counter.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  input  logic                     drop_clr,
  output logic [7:0]               drop_cnt
);

  logic [NUM_CH-1:0] drain;
  logic [NUM_CH-1:0] free;
  logic [NUM_CH-1:0] target;
  logic [NUM_CH-1:0] load;
  logic              accept;
  logic              drop;
  logic [DATA_W-1:0] slot_data [NUM_CH];

  // Out-of-range selects never match any channel, so they fall through to a drop.
  always_comb begin
    // NOTE: default every always_comb output first so no path can infer a latch.
    target = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      target[k] = ch_en[k] & (in_bcast | (in_sel == SEL_W'(k)));
    end
  end

  assign drain    = out_valid & out_ready;
  assign free     = ~out_valid | drain;
  // All targets must be free together, which is what makes broadcast atomic.
  assign in_ready = rst_n & ~|(target & ~free);
  assign accept   = in_valid & in_ready;
  assign load     = target & {NUM_CH{accept}};
  assign drop     = accept & ~|target;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      // NOTE: the slot array is reset on purpose because out_data must read zero after reset.
      for (int k = 0; k < NUM_CH; k++) slot_data[k] <= '0;
    end else begin
      out_valid <= load | (out_valid & ~drain);
      for (int k = 0; k < NUM_CH; k++) begin
        if (load[k]) slot_data[k] <= in_data;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      out_data[k*DATA_W +: DATA_W] = slot_data[k];
    end
  end

  // Clear wins over a coincident drop; the count sticks at its maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop_clr) begin
      drop_cnt <= '0;
    end else if (drop && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: directed scenarios plus random traffic
// compared against a queue-based scoreboard; a 3-channel instance covers out-of-range selects.
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic [3:0]  ch_en;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        drop_clr;
  logic [7:0]  drop_cnt;

  logic        v3, r3, bc3, clr3;
  logic [7:0]  d3;
  logic [1:0]  sel3;
  logic [2:0]  en3, ov3, or3;
  logic [23:0] od3;
  logic [7:0]  cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q [4][$];
  logic [7:0] last_data [4];
  int         mdl_drop;

  always #5 clk = ~clk;

  stream_demux #(.DATA_W(8), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast), .ch_en(ch_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_clr(drop_clr), .drop_cnt(drop_cnt)
  );

  stream_demux #(.DATA_W(8), .NUM_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3),
    .in_data(d3), .in_sel(sel3), .in_bcast(bc3), .ch_en(en3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .drop_clr(clr3), .drop_cnt(cnt3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic b, input logic [7:0] d,
                       input logic [3:0] en, input logic [3:0] ordy, input logic clr);
    in_valid  = v;
    in_sel    = s;
    in_bcast  = b;
    in_data   = d;
    ch_en     = en;
    out_ready = ordy;
    drop_clr  = clr;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      last_data[k] = 8'h00;
    end
    mdl_drop = 0;
  endtask

  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    logic [3:0] tset;
    logic       rdy;
    #1;
    tset = 4'b0000;
    if (in_bcast) tset = ch_en;
    else if (ch_en[in_sel]) tset[in_sel] = 1'b1;
    rdy = 1'b1;
    for (int k = 0; k < 4; k++)
      if (tset[k] && q[k].size() != 0 && !out_ready[k]) rdy = 1'b0;
    check("in_ready", in_ready, rdy);
    check("drop_cnt", drop_cnt, mdl_drop);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("out_valid[%0d]", k), out_valid[k], q[k].size() != 0);
      check($sformatf("out_data[%0d]", k), out_data[k*8 +: 8],
            (q[k].size() != 0) ? q[k][0] : last_data[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++)
      if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
    if (in_valid && rdy) begin
      if (tset == 4'b0000) begin
        if (mdl_drop < 255) mdl_drop++;
      end else begin
        for (int k = 0; k < 4; k++)
          if (tset[k]) begin
            q[k].push_back(in_data);
            last_data[k] = in_data;
          end
      end
    end
    if (drop_clr) mdl_drop = 0;
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'd3, 1'b0, 8'h00, 4'hF, 4'hF, 1'b0);
    v3 = 1'b0; sel3 = 2'd0; bc3 = 1'b0; d3 = 8'h00; en3 = 3'b111; or3 = 3'b111; clr3 = 1'b0;
    #3;
    check("reset in_ready", in_ready, 1'b0);
    check("reset out_valid", out_valid, 4'h0);
    check("reset out_data", out_data, 32'h0);
    check("reset drop_cnt", drop_cnt, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-channel instance: out-of-range select, disabled target, empty broadcast.
    v3 = 1'b1; sel3 = 2'd3; d3 = 8'hE1;
    #1 check("n3 range in_ready", r3, 1'b1);
    @(negedge clk);
    sel3 = 2'd1; en3 = 3'b101; d3 = 8'hE2;
    #1 check("n3 disabled in_ready", r3, 1'b1);
    @(negedge clk);
    bc3 = 1'b1; en3 = 3'b000; d3 = 8'hE3;
    #1 check("n3 bcast0 in_ready", r3, 1'b1);
    @(negedge clk);
    v3 = 1'b0;
    #1 check("n3 drop_cnt", cnt3, 8'd3);
    check("n3 out_valid", ov3, 3'b000);
    @(negedge clk);
    v3 = 1'b1; clr3 = 1'b1;
    @(negedge clk);
    v3 = 1'b0; clr3 = 1'b0; bc3 = 1'b0;
    #1 check("n3 clr priority", cnt3, 8'd0);
    @(negedge clk);
    v3 = 1'b1; sel3 = 2'd2; en3 = 3'b111; or3 = 3'b000; d3 = 8'hB7;
    @(negedge clk);
    v3 = 1'b0;
    #1 check("n3 unicast valid", ov3, 3'b100);
    check("n3 unicast data", od3, 24'hB70000);
    @(negedge clk);

    // Unicast streaming, back to back.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b0, 8'(8'h11 * (i + 1)), 4'hF, 4'hF, 1'b0);
      step();
    end
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 4'hF, 1'b0);
    step();
    step();

    // Backpressure on channel 2, then drain-and-reload on one edge.
    drive(1'b1, 2'd2, 1'b0, 8'hA5, 4'hF, 4'b1011, 1'b0);
    step();
    drive(1'b1, 2'd2, 1'b0, 8'h5A, 4'hF, 4'b1011, 1'b0);
    step();
    step();
    check("bp held data", out_data[23:16], 8'hA5);
    check("bp held ready", in_ready, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 8'h5A, 4'hF, 4'hF, 1'b0);
    step();
    check("bp reload valid", out_valid[2], 1'b1);
    check("bp reload data", out_data[23:16], 8'h5A);
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 4'hF, 1'b0);
    step();

    // Broadcast atomicity with channel 3 stalled.
    drive(1'b1, 2'd3, 1'b0, 8'h33, 4'hF, 4'b0111, 1'b0);
    step();
    drive(1'b1, 2'd0, 1'b1, 8'h7E, 4'b1011, 4'b0111, 1'b0);
    step();
    step();
    check("bc stalled valid", out_valid, 4'b1000);
    drive(1'b1, 2'd0, 1'b1, 8'h7E, 4'b1011, 4'hF, 1'b0);
    step();
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 4'h0, 1'b0);
    step();
    check("bc loaded valid", out_valid, 4'b1011);
    check("bc loaded data", out_data, 32'h7E5A7E7E);
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 4'hF, 1'b0);
    step();

    // Drops on the four-channel instance, then clear racing a drop.
    drive(1'b1, 2'd1, 1'b0, 8'hD1, 4'b1101, 4'hF, 1'b0);
    step();
    drive(1'b1, 2'd0, 1'b1, 8'hD2, 4'b0000, 4'hF, 1'b0);
    step();
    check("drops count", drop_cnt, 8'd2);
    drive(1'b1, 2'd0, 1'b1, 8'hD3, 4'b0000, 4'hF, 1'b1);
    step();
    check("drop clr priority", drop_cnt, 8'd0);

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd0, 1'b1, 8'(i), 4'b0000, 4'hF, 1'b0);
      step();
    end
    check("drop saturate", drop_cnt, 8'd255);
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 4'hF, 1'b0);
    step();
    check("drop hold", drop_cnt, 8'd255);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 4) == 0),
            8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF,
            4'($urandom), 1'($urandom_range(0, 40) == 0));
      step();
    end

    // Asynchronous reset with three slots full.
    drive(1'b1, 2'd0, 1'b1, 8'h00, 4'b0000, 4'hF, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'(i), 1'b0, 8'(8'hC0 + i), 4'hF, 4'h0, 1'b0);
      step();
    end
    drive(1'b0, 2'd3, 1'b0, 8'h00, 4'hF, 4'h0, 1'b0);
    @(posedge clk);
    #2;
    check("pre-reset valid", out_valid, 4'b0111);
    rst_n = 1'b0;
    #1;
    check("async out_valid", out_valid, 4'h0);
    check("async out_data", out_data, 32'h0);
    check("async drop_cnt", drop_cnt, 8'h00);
    check("async in_ready", in_ready, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd1, 1'b0, 8'hD0, 4'hF, 4'hF, 1'b0);
    step();
    drive(1'b0, 2'd0, 1'b0, 8'h00, 4'hF, 4'hF, 1'b0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
